// File: rtl/lp_pkg.sv
// Shared definitions for the lowpass/decimation return path: sample
// counts on each side of the rate converter and the start/run state type.
package lp_pkg;

    // Samples delivered per enabled clock by the six-wide filter output.
    localparam int LP_IN_SAMPLES   = 6;
    // Samples produced per clock on the native four-wide datapath.
    localparam int LP_OUT_SAMPLES  = 4;
    // Buffer fill at which the converter starts draining.
    localparam int LP_START_THRESH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lp_state_t;

endpackage

// File: rtl/lp_six_to_four.sv
// Six-wide (gated by ce_i) to four-wide (every clock) sample re-packer.
// An elastic sample buffer absorbs the 2-of-3 input cadence; a start/run
// state machine waits for enough fill before draining, and any overflow or
// underflow flushes the buffer and restarts from IDLE.
//
// Interface: ce_i qualifies dat_i for exactly one clock and is always
// accepted (there is no back-pressure). valid_o qualifies dat_o for exactly
// one clock; downstream has no ready and must take every valid beat.
// err_o is a one-clock pulse in the clock after a fault.
module lp_six_to_four
    import lp_pkg::*;
#(
    parameter int NBITS       = 12,
    parameter int BUF_SAMPLES = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [LP_IN_SAMPLES*NBITS-1:0]    dat_i,
    input  logic                              ce_i,
    output logic [LP_OUT_SAMPLES*NBITS-1:0]   dat_o,
    output logic                              valid_o,
    output logic                              err_o
);

    localparam int FW = $clog2(BUF_SAMPLES + 1);
    // One spare bit so fill arithmetic above the depth is visible.
    localparam int IW = FW + 1;
    typedef logic [IW-1:0] idx_t;

    localparam idx_t DEPTH  = idx_t'(BUF_SAMPLES);
    localparam idx_t IN_N   = idx_t'(LP_IN_SAMPLES);
    localparam idx_t OUT_N  = idx_t'(LP_OUT_SAMPLES);
    localparam idx_t THRESH = idx_t'(LP_START_THRESH);

    // Buffer slot 0 always holds the oldest sample.
    logic [NBITS-1:0]                buf_q [BUF_SAMPLES];
    logic [NBITS-1:0]                buf_d [BUF_SAMPLES];
    logic [FW-1:0]                   fill_q, fill_d;
    lp_state_t                       state_q, state_d;
    logic [LP_OUT_SAMPLES*NBITS-1:0] dat_q, dat_d;
    logic                            valid_q, valid_d;
    logic                            err_q, err_d;

    logic pop;
    logic underflow;
    logic overflow;
    idx_t fill_ext;
    idx_t base;
    idx_t fill_next;

    // Fill bookkeeping: where this clock's push lands and whether it faults.
    always_comb begin
        pop       = (state_q == RUN);
        fill_ext  = idx_t'(fill_q);
        underflow = pop && (fill_ext < OUT_N);
        // base wraps on underflow; that case is excluded from overflow below.
        base      = pop ? (fill_ext - OUT_N) : fill_ext;
        fill_next = base + (ce_i ? IN_N : '0);
        overflow  = !underflow && (fill_next > DEPTH);
    end

    // Next-state logic for the buffer, fill counter, state and outputs.
    always_comb begin
        buf_d   = buf_q;
        fill_d  = fill_q;
        state_d = state_q;
        dat_d   = dat_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (underflow || overflow) begin
            // Flush discards everything, including a push arriving this clock.
            fill_d  = '0;
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            if (pop) begin
                for (int k = 0; k < LP_OUT_SAMPLES; k++) begin
                    dat_d[k*NBITS +: NBITS] = buf_q[k];
                end
                valid_d = 1'b1;
                for (int i = 0; i < BUF_SAMPLES - LP_OUT_SAMPLES; i++) begin
                    buf_d[i] = buf_q[i + LP_OUT_SAMPLES];
                end
                for (int i = BUF_SAMPLES - LP_OUT_SAMPLES; i < BUF_SAMPLES; i++) begin
                    buf_d[i] = '0;
                end
            end
            if (ce_i) begin
                // Append after the surviving samples, oldest input first.
                for (int i = 0; i < BUF_SAMPLES; i++) begin
                    for (int k = 0; k < LP_IN_SAMPLES; k++) begin
                        if (base + idx_t'(k) == idx_t'(i)) begin
                            buf_d[i] = dat_i[k*NBITS +: NBITS];
                        end
                    end
                end
            end
            fill_d = fill_next[FW-1:0];
            if ((state_q == IDLE) && (fill_ext >= THRESH)) begin
                state_d = RUN;
            end
        end
    end

    // All state and registered outputs; reset wins over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            fill_q  <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < BUF_SAMPLES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
        end
    end

    assign dat_o   = dat_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_lp_six_to_four.sv
// Bench for lp_six_to_four: directed cadence scenarios followed by random
// traffic, checked by a scoreboard fed from a queue-based sample model.
module tb_lp_six_to_four;

    localparam int NBITS       = 12;
    localparam int BUF_SAMPLES = 16;
    localparam int IW          = 6 * NBITS;
    localparam int OW          = 4 * NBITS;

    logic          clk;
    logic          rst_i;
    logic          ce_i;
    logic [IW-1:0] dat_i;
    logic [OW-1:0] dat_o;
    logic          valid_o;
    logic          err_o;

    lp_six_to_four #(
        .NBITS       (NBITS),
        .BUF_SAMPLES (BUF_SAMPLES)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .dat_i   (dat_i),
        .ce_i    (ce_i),
        .dat_o   (dat_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [OW-1:0]    exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    // Reference model: the buffer as a plain sample queue plus a running flag.
    logic [NBITS-1:0] model_q[$];
    bit               model_run = 1'b0;

    bit               armed     = 1'b0;
    bit               exp_valid = 1'b0;
    bit               exp_err   = 1'b0;
    bit               exp_zero  = 1'b0;
    int               clk_idx   = 0;
    int               cur_clk   = 0;
    int               first_valid_clk = -1;
    logic [OW-1:0]    first_valid_word = '0;
    int               err_seen  = 0;
    logic [NBITS-1:0] ramp      = '0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model predicts what the following edge does.
    task automatic step(input bit rst, input bit ce, input logic [IW-1:0] dat);
        int            start;
        int            nxt;
        logic [OW-1:0] word;
        @(negedge clk);
        rst_i    = rst;
        ce_i     = ce;
        dat_i    = dat;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_zero  = rst;
        if (rst) begin
            model_q.delete();
            model_run = 1'b0;
        end else begin
            start = model_q.size();
            nxt   = start + (ce ? 6 : 0) - (model_run ? 4 : 0);
            if ((model_run && start < 4) || nxt > BUF_SAMPLES) begin
                model_q.delete();
                model_run = 1'b0;
                exp_err   = 1'b1;
            end else begin
                if (model_run) begin
                    word = '0;
                    for (int k = 0; k < 4; k++) word[k*NBITS +: NBITS] = model_q.pop_front();
                    exp_q.push_back(word);
                    exp_valid = 1'b1;
                end
                if (ce) begin
                    for (int k = 0; k < 6; k++) model_q.push_back(dat[k*NBITS +: NBITS]);
                end
                if (!model_run && start >= 8) model_run = 1'b1;
            end
        end
        cur_clk = clk_idx;
        clk_idx++;
        armed = 1'b1;
    endtask

    // Ramp data on enabled clocks, junk otherwise (must be ignored).
    task automatic drive_ce(input bit ce);
        logic [IW-1:0] d;
        logic [95:0]   r;
        if (ce) begin
            for (int k = 0; k < 6; k++) begin
                d[k*NBITS +: NBITS] = ramp;
                ramp = ramp + 1'b1;
            end
        end else begin
            r = {$urandom(), $urandom(), $urandom()};
            d = r[IW-1:0];
        end
        step(1'b0, ce, d);
    endtask

    function automatic logic [OW-1:0] ramp_word(input logic [NBITS-1:0] s0);
        logic [OW-1:0] w;
        for (int k = 0; k < 4; k++) w[k*NBITS +: NBITS] = s0 + NBITS'(k);
        return w;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [OW-1:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                check("valid_o", OW'(valid_o), OW'(exp_valid));
                check("err_o", OW'(err_o), OW'(exp_err));
                if (exp_zero) check("dat_o_after_reset", dat_o, '0);
                if (exp_valid) begin
                    w = exp_q.pop_front();
                    if (valid_o === 1'b1) check("dat_o", dat_o, w);
                end
                if (err_o === 1'b1) err_seen++;
                if (valid_o === 1'b1 && first_valid_clk < 0) begin
                    first_valid_clk  = cur_clk + 1;
                    first_valid_word = dat_o;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int               err_base;
        logic [NBITS-1:0] restart_sample;
        logic [95:0]      r;
        rst_i = 1'b1;
        ce_i  = 1'b0;
        dat_i = '0;

        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);

        // Ramp with cadence 1,1,0 from clock 0.
        clk_idx = 0;
        first_valid_clk = -1;
        err_base = err_seen;
        for (int i = 0; i < 300; i++) drive_ce(i % 3 != 2);
        check("first_valid_clock_110", OW'(first_valid_clk), OW'(4));
        check("first_word_110", first_valid_word, ramp_word('0));
        check("no_err_110", OW'(err_seen - err_base), '0);

        // Ramp with cadence 1,0,1 once running.
        step(1'b1, 1'b0, '0);
        err_base = err_seen;
        for (int i = 0; i < 300; i++) drive_ce((i < 3) ? (i != 2) : ((i - 3) % 3 != 1));
        check("no_err_101", OW'(err_seen - err_base), '0);

        // Underflow: three idle clocks in RUN, then traffic resumes.
        err_base = err_seen;
        for (int i = 0; i < 3; i++) drive_ce(1'b0);
        drive_ce(1'b1);
        for (int j = 0; j < 30; j++) drive_ce(j % 3 != 2);
        check("underflow_err_count", OW'(err_seen - err_base), OW'(1));

        // Overflow: four enabled clocks in a row while running.
        err_base = err_seen;
        for (int i = 0; i < 4; i++) drive_ce(1'b1);
        drive_ce(1'b0);
        drive_ce(1'b1);
        drive_ce(1'b0);
        for (int m = 0; m < 21; m++) drive_ce(m % 3 != 2);
        drive_ce(1'b1);
        drive_ce(1'b0);
        check("overflow_err_count", OW'(err_seen - err_base), OW'(1));

        // Reset mid-stream with ten samples buffered, then restart.
        step(1'b1, 1'b1, '1);
        clk_idx = 0;
        first_valid_clk = -1;
        restart_sample = ramp;
        err_base = err_seen;
        for (int i = 0; i < 30; i++) drive_ce(i % 3 != 2);
        check("first_valid_clock_restart", OW'(first_valid_clk), OW'(4));
        check("first_word_restart", first_valid_word, ramp_word(restart_sample));
        check("no_err_restart", OW'(err_seen - err_base), '0);

        // Random cadence, data and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, r[IW-1:0]);
        end

        step(1'b0, 1'b0, '0);
        @(posedge clk);
        #2;
        armed = 1'b0;
        check("scoreboard_drained", OW'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
